// File: rtl/ov_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov_stream_pkg
// Description : Shared types, pattern-mode codes, RGB565 bar palette and
//               frame-geometry helpers for the OV7670-style stream source.
// Revision    : 1.0 - initial release
// ============================================================================
package ov_stream_pkg;

    // Timing FSM states; encodings are fixed so that debug taps read stably
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFP    = 3'd4
    } ov_state_t;

    // Test-pattern selectors
    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    // Classic eight-bar palette in RGB565, left to right
    function automatic logic [15:0] bar_rgb565(input logic [2:0] bar);
        logic [15:0] rgb;
        case (bar)
            3'd0:    rgb = 16'hFFFF;   // white
            3'd1:    rgb = 16'hFFE0;   // yellow
            3'd2:    rgb = 16'h07FF;   // cyan
            3'd3:    rgb = 16'h07E0;   // green
            3'd4:    rgb = 16'hF81F;   // magenta
            3'd5:    rgb = 16'hF800;   // red
            3'd6:    rgb = 16'h001F;   // blue
            default: rgb = 16'h0000;   // black
        endcase
        return rgb;
    endfunction

    // Beats per line: active bytes plus horizontal blanking
    function automatic int h_total(input int h_active, input int bpp, input int h_blank);
        return h_active * bpp + h_blank;
    endfunction

    // Lines per frame: sync, back porch, active and front porch
    function automatic int v_total(input int vs_w, input int v_bp,
                                   input int v_active, input int v_fp);
        return vs_w + v_bp + v_active + v_fp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov_pattern_lut.sv
`default_nettype none
// ============================================================================
// Module      : ov_pattern_lut
// Description : Combinational test-pattern generator. Maps pixel position,
//               frame parity and the selected mode to one PIX_W-bit pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module ov_pattern_lut
    import ov_stream_pkg::*;
#(
    parameter int PIX_W    = 16,
    parameter int H_ACTIVE = 640
) (
    input  logic [1:0]       mode,
    input  logic [15:0]      x,
    input  logic             y_bit3,
    input  logic             frame_lsb,
    input  logic [PIX_W-1:0] const_val,
    output logic [PIX_W-1:0] pixel
);

    logic [18:0] w_x8;
    logic [18:0] w_bar_q;
    logic [2:0]  w_bar;

    // Pattern selection; bar index is clamped so blanking-time x never aliases
    always_comb begin
        w_x8    = {x, 3'b000};
        w_bar_q = w_x8 / 19'(H_ACTIVE);
        w_bar   = (w_bar_q > 19'd7) ? 3'd7 : w_bar_q[2:0];
        pixel   = '0;
        case (mode)
            MODE_CONST: pixel = const_val;
            MODE_RAMP:  pixel = PIX_W'(x);
            MODE_BARS:  pixel = (PIX_W == 16) ? PIX_W'(bar_rgb565(w_bar)) : PIX_W'(w_bar);
            MODE_CHECK: pixel = {PIX_W{x[3] ^ y_bit3 ^ frame_lsb}};
            default:    pixel = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ov_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : ov_stream_gen
// Description : Parametrised OV7670-style camera source. Emits vsync/href and
//               byte-serial pixel data on an emulated PCLK beat strobe, with
//               selectable test patterns. Counters are 16 bits wide, which
//               bounds every timing parameter to 65535.
// Revision    : 1.0 - initial release
// ============================================================================
module ov_stream_gen
    import ov_stream_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BPP      = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_ACTIVE = 480,
    parameter int VS_W     = 3,
    parameter int V_BP     = 17,
    parameter int V_FP     = 10,
    parameter int CLK_DIV  = 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_W*BPP-1:0] const_val,
    output logic                  ov_vsync,
    output logic                  ov_href,
    output logic                  ov_beat,
    output logic [DATA_W-1:0]     ov_data,
    output logic [15:0]           frame_cnt,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int PIX_W       = DATA_W * BPP;
    localparam int H_TOTAL     = h_total(H_ACTIVE, BPP, H_BLANK);
    localparam int H_ACT_BEATS = H_ACTIVE * BPP;
    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int B_W         = (BPP > 1) ? $clog2(BPP) : 1;

    // Position of the next beat to be emitted
    ov_state_t        r_state;
    logic [15:0]      r_h;       // beat within line
    logic [15:0]      r_v;       // line within current state
    logic [15:0]      r_x;       // pixel column, tracks r_h / BPP
    logic [B_W-1:0]   r_b;       // byte index, tracks r_h % BPP
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_mode;

    logic             w_beat;
    logic             w_line_end;
    logic             w_last_line;
    logic             w_href;
    logic [15:0]      w_lines;
    logic [DIV_W-1:0] w_div_next;
    logic [PIX_W-1:0] w_pix;
    logic [DATA_W-1:0] w_byte;

    ov_pattern_lut #(
        .PIX_W    (PIX_W),
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_lut (
        .mode      (r_mode),
        .x         (r_x),
        .y_bit3    (r_v[3]),
        .frame_lsb (frame_cnt[0]),
        .const_val (const_val),
        .pixel     (w_pix)
    );

    assign busy = (r_state != S_IDLE);

    // Beat strobe, line/state boundary detection and MSB-first byte select
    always_comb begin
        w_beat     = (r_div == '0);
        w_div_next = (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
        w_line_end = (r_h == 16'(H_TOTAL - 1));
        case (r_state)
            S_VSYNC:  w_lines = 16'(VS_W);
            S_VBP:    w_lines = 16'(V_BP);
            S_ACTIVE: w_lines = 16'(V_ACTIVE);
            S_VFP:    w_lines = 16'(V_FP);
            default:  w_lines = 16'd1;
        endcase
        w_last_line = (r_v == w_lines - 16'd1);
        w_href      = (r_state == S_ACTIVE) && (r_h < 16'(H_ACT_BEATS));
        w_byte      = '0;
        for (int i = 0; i < BPP; i++) begin
            if (r_b == B_W'(i)) begin
                w_byte = w_pix[PIX_W-1-i*DATA_W -: DATA_W];
            end
        end
    end

    // Timing FSM: on each beat, register the outputs for the current position
    // and then advance it; outputs are held between beats
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_h        <= '0;
            r_v        <= '0;
            r_x        <= '0;
            r_b        <= '0;
            r_div      <= '0;
            r_mode     <= MODE_CONST;
            ov_vsync   <= 1'b0;
            ov_href    <= 1'b0;
            ov_beat    <= 1'b0;
            ov_data    <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            ov_beat    <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_VSYNC;
                        r_mode  <= mode;
                        r_h     <= '0;
                        r_v     <= '0;
                        r_x     <= '0;
                        r_b     <= '0;
                        r_div   <= '0;
                    end
                end
                default: begin
                    r_div <= w_div_next;
                    if (w_beat) begin
                        ov_beat  <= 1'b1;
                        ov_vsync <= (r_state == S_VSYNC);
                        ov_href  <= w_href;
                        ov_data  <= w_href ? w_byte : '0;
                        if (w_line_end) begin
                            r_h <= '0;
                            r_x <= '0;
                            r_b <= '0;
                            if (w_last_line) begin
                                r_v <= '0;
                                case (r_state)
                                    S_VSYNC:  r_state <= S_VBP;
                                    S_VBP:    r_state <= S_ACTIVE;
                                    S_ACTIVE: r_state <= S_VFP;
                                    S_VFP: begin
                                        frame_done <= 1'b1;
                                        frame_cnt  <= frame_cnt + 16'd1;
                                        if (enable) begin
                                            r_state <= S_VSYNC;
                                            r_mode  <= mode;
                                        end else begin
                                            r_state <= S_IDLE;
                                        end
                                    end
                                    default:  r_state <= S_IDLE;
                                endcase
                            end else begin
                                r_v <= r_v + 16'd1;
                            end
                        end else begin
                            r_h <= r_h + 16'd1;
                            if (r_b == B_W'(BPP - 1)) begin
                                r_b <= '0;
                                r_x <= r_x + 16'd1;
                            end else begin
                                r_b <= r_b + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
